// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to a single requester per interval.
// The owner holds grant for len cycles (0 means 2^WIDTH) and gets a one-cycle done pulse.
module counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [WIDTH-1:0]         count,
  output logic [NUM_REQ-1:0]       done
);
  // state | meaning
  // IDLE  | no owner; arbitrate among req starting after last
  // RUN   | owner granted, shared counter advancing
  // DONE  | single completion-pulse cycle, no arbitration
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t             state, state_n;
  logic [IW-1:0]      last, last_n;
  logic [IW-1:0]      owner, owner_n;
  logic [IW-1:0]      win_idx, cand;
  logic               win_found;
  logic [WIDTH-1:0]   len_l, len_l_n;
  logic [WIDTH-1:0]   count_n;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic               busy_n;

  // First requester at or after last+1, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    owner_n = owner;
    len_l_n = len_l;
    grant_n = grant;
    busy_n  = busy;
    count_n = count;
    done_n  = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n          = RUN;
          grant_n          = '0;
          grant_n[win_idx] = 1'b1;
          busy_n           = 1'b1;
          count_n          = '0;
          len_l_n          = len[int'(win_idx)*WIDTH +: WIDTH];
          last_n           = win_idx;
          owner_n          = win_idx;
        end
      end
      RUN: begin
        if (!req[owner]) begin
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
        end else if (count == len_l - ONE) begin
          // modular compare: len_l of 0 terminates at all-ones
          state_n       = DONE;
          grant_n       = '0;
          done_n[owner] = 1'b1;
        end else begin
          count_n = count + ONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= IW'(NUM_REQ - 1);
      owner <= '0;
      len_l <= '0;
      grant <= '0;
      busy  <= 1'b0;
      count <= '0;
      done  <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      owner <= owner_n;
      len_l <= len_l_n;
      grant <= grant_n;
      busy  <= busy_n;
      count <= count_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: an interval-level model predicts grant/done/abort
// events at each clock edge, and a negedge monitor matches them against the DUT.
module tb_counter_arbiter;
  localparam int N = 4;
  localparam int W = 5;
  localparam int K_GRANT = 1;
  localparam int K_DONE  = 2;
  localparam int K_ABORT = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] len = '0;
  logic [N-1:0] grant;
  logic         busy;
  logic [W-1:0] count;
  logic [N-1:0] done;

  counter_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len),
    .grant(grant), .busy(busy), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int idx; int cnt; int dur; } ev_t;
  ev_t sb[$];
  int  gq[$];
  int  checks = 0;
  int  errors = 0;

  int m_owner, m_last, m_cnt, m_len;
  bit m_cool, m_evt;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push_ev(int k, int i, int c, int d);
    ev_t e;
    e.kind = k; e.idx = i; e.cnt = c; e.dur = d;
    sb.push_back(e);
  endfunction

  function automatic int oh_idx(logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic void m_reset();
    m_owner = -1; m_last = N - 1; m_cnt = 0; m_len = 0; m_cool = 0; m_evt = 0;
    sb.delete();
  endfunction

  // One clock edge of the interval model, using the inputs the DUT samples on it.
  function automatic void m_step();
    int w;
    w = -1;
    if (m_cool) begin
      m_cool = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (w < 0 && req[c]) w = c;
      end
      if (w >= 0) begin
        m_owner = w; m_last = w; m_cnt = 0;
        m_len = int'(len[w*W +: W]);
        if (m_len == 0) m_len = 1 << W;
        push_ev(K_GRANT, w, 0, 0);
      end
    end else if (!req[m_owner]) begin
      push_ev(K_ABORT, m_owner, m_cnt, 0);
      m_owner = -1; m_evt = 1;
    end else if (m_cnt == m_len - 1) begin
      push_ev(K_DONE, m_owner, m_cnt, m_len);
      m_owner = -1; m_cool = 1; m_evt = 1;
    end else begin
      m_cnt++;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    m_step();
    #1;
  endtask

  // Called 1 time unit after a posedge; reset spans the following negedge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_count", int'(count), 0);
    chk("rst_done",  int'(done),  0);
    m_reset();
    #4 reset = 1'b0;
  endtask

  task automatic set_len(int i, int v);
    len[i*W +: W] = W'(v);
  endtask

  task automatic run_until_end(int maxc);
    int n = 0;
    m_evt = 0;
    do begin step(); n++; end while (!m_evt && n < maxc);
    if (!m_evt) begin
      checks++; errors++;
      $display("FAIL run_timeout actual=%0d cycles expected=interval end", n);
    end
  endtask

  task automatic wait_cnt(int target, int maxc);
    int n = 0;
    do begin step(); n++; end while (!(m_owner >= 0 && m_cnt == target) && n < maxc);
    if (!(m_owner >= 0 && m_cnt == target)) begin
      checks++; errors++;
      $display("FAIL wait_timeout actual=%0d cycles expected=count %0d", n, target);
    end
  endtask

  task automatic chk_grant(string nm, int base, int exp);
    chk(nm, (gq.size() > base) ? gq[base] : -1, exp);
  endtask

  // Monitor: matches DUT events against the scoreboard queue on every negedge.
  initial begin
    logic [N-1:0] p_grant, p_done;
    logic p_busy;
    int gcyc;
    ev_t e;
    p_grant = '0; p_done = '0; p_busy = 1'b0; gcyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_grant = '0; p_done = '0; p_busy = 1'b0; gcyc = 0;
        continue;
      end
      chk("invariants", ($onehot0(grant) && $onehot0(done) && !(|grant && |done)) ? 1 : 0, 1);
      if (done != 0 || (grant != 0 && grant != p_grant) || (p_busy && !busy && p_done == 0)) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event actual=grant %b done %b busy %0d expected=no event",
                   grant, done, busy);
        end else begin
          e = sb.pop_front();
          if (done != 0) begin
            chk("done_kind",  K_DONE, e.kind);
            chk("done_idx",   oh_idx(done), e.idx);
            chk("done_count", int'(count), e.cnt);
            chk("done_len",   gcyc, e.dur);
            chk("done_busy",  int'(busy), 1);
          end else if (grant != 0) begin
            chk("grant_kind",  K_GRANT, e.kind);
            chk("grant_idx",   oh_idx(grant), e.idx);
            chk("grant_count", int'(count), 0);
            chk("grant_busy",  int'(busy), 1);
            gq.push_back(oh_idx(grant));
            gcyc = 1;
          end else begin
            chk("abort_kind",  K_ABORT, e.kind);
            chk("abort_idx",   oh_idx(p_grant), e.idx);
            chk("abort_count", int'(count), e.cnt);
          end
        end
      end
      if (grant != 0 && grant == p_grant) gcyc++;
      chk("no_missing_event", sb.size(), 0);
      sb.delete();
      p_grant = grant; p_done = done; p_busy = busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    m_reset();
    do_reset();

    // Single short interval on requester 0
    set_len(0, 3); req = 4'b0001;
    base = gq.size();
    run_until_end(10);
    req = 4'b0000;
    step(); step();
    chk_grant("t1_first", base, 0);
    chk("t1_idle_busy", int'(busy), 0);

    // Round-robin rotation after reset, len 1 everywhere
    do_reset();
    len = {N{W'(1)}}; req = 4'b1111;
    base = gq.size();
    repeat (13) step();
    req = 4'b0000;
    step(); step();
    chk_grant("rr_0", base,     0);
    chk_grant("rr_1", base + 1, 1);
    chk_grant("rr_2", base + 2, 2);
    chk_grant("rr_3", base + 3, 3);
    chk_grant("rr_4", base + 4, 0);

    // len 0 = full 2^W interval; count holds in IDLE
    set_len(2, 0); req = 4'b0100;
    run_until_end(40);
    req = 4'b0000;
    step(); step();
    chk("idle_hold", int'(count), 31);

    // Abort at count 4, then priority after aborted owner
    set_len(1, 10); req = 4'b0010;
    wait_cnt(4, 20);
    req = 4'b0000;
    step(); step();
    chk("abort_hold", int'(count), 4);
    chk("abort_done", int'(done), 0);
    base = gq.size();
    set_len(3, 3); req = 4'b1010;
    step(); step();
    chk_grant("abort_next", base, 3);
    req = 4'b0000;
    step(); step();

    // Reset mid-run, then priority restarts at requester 0
    set_len(2, 8); req = 4'b0100;
    wait_cnt(5, 20);
    do_reset();
    base = gq.size();
    req = 4'b1111;
    step(); step();
    chk_grant("rst_next", base, 0);
    req = 4'b0000;
    step(); step();

    // len change mid-run is ignored; next grant goes to requester 1
    do_reset();
    set_len(0, 5); set_len(1, 4); req = 4'b0001;
    wait_cnt(1, 10);
    set_len(0, 2);
    run_until_end(10);
    base = gq.size();
    req = 4'b0011;
    step(); step(); step();
    chk_grant("len_next", base, 1);
    req = 4'b0000;
    step(); step();

    // Randomized traffic with occasional abandons and resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ($urandom_range(99) < 3) req[i] = 1'b0;
        end else if ($urandom_range(99) < 20) begin
          req[i] = 1'b1;
        end
      end
      if ($urandom_range(99) < 30) len = (N*W)'($urandom);
      step();
      if ($urandom_range(999) < 3) do_reset();
    end
    req = '0;
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
